spart_echo_driver: RTL and testbench

//  Bus master for the SPART: programs the baud divisor, then echoes received bytes back to the transmitter.
//  A parametrised FIFO between receive and transmit buffers the echo path, so RX bursts are absorbed while TX drains.
//  It reprograms the divisor whenever br_cfg changes at run time. Sits between board switches/LEDs and the spart bus.

---
 rtl/spart_drv_pkg.sv | 33 +++
 rtl/spart_echo_driver_if.sv | 13 +
 rtl/spart_byte_fifo.sv | 56 +++++
 rtl/spart_echo_driver.sv | 163 ++++++++++++++++
 tb/tb_spart_echo_driver.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spart_drv_pkg.sv
// Shared definitions for the SPART echo driver: bus register addresses,
// FSM state encoding, default baud divisors and the transmit case-swap helper.
package spart_drv_pkg;

    // SPART register map as seen on ioaddr
    localparam logic [1:0] ADDR_DATA = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    // Divisors for a 100 MHz clock: 4800, 9600, 19200, 38400 baud
    localparam logic [15:0] DEF_DIV0 = 16'h0516;
    localparam logic [15:0] DEF_DIV1 = 16'h028B;
    localparam logic [15:0] DEF_DIV2 = 16'h0146;
    localparam logic [15:0] DEF_DIV3 = 16'h00A3;

    // Read and write strobes are issued straight out of IDLE, so they are
    // not separate register states; every strobe is followed by GAP.
    typedef enum logic [1:0] {
        ST_CFG_LO = 2'd0,
        ST_CFG_HI = 2'd1,
        ST_GAP    = 2'd2,
        ST_IDLE   = 2'd3
    } drv_state_e;

    // Flip the case of ASCII letters, leave everything else untouched
    function automatic logic [7:0] case_swap(input logic [7:0] b);
        if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A))
            return b ^ 8'h20;
        return b;
    endfunction

endpackage

// File: rtl/spart_echo_driver_if.sv
// Control side of the SPART bus: chip select, direction, address and the
// two status lines coming back from the SPART. The data bus is bidirectional
// and stays a plain inout port on the driver.
interface spart_echo_driver_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, iorw, ioaddr, input rda, tbr);
    modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_byte_fifo.sv
// 8-bit synchronous FIFO for the echo path. DEPTH must be a power of two so
// the pointers wrap naturally; level counts 0..DEPTH inclusive.
module spart_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is data only and is never cleared; occupancy tracks validity
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/spart_echo_driver.sv
// SPART bus master: programs the baud divisor selected by br_cfg, then echoes
// every received byte back through an internal FIFO. A change of br_cfg seen
// in IDLE reprograms the divisor without disturbing the FIFO.
// Build option: define SPART_DRV_CASE_SWAP_EN to invert the case of ASCII
// letters on transmit (FIFO and driver_led keep the byte as received).
module spart_echo_driver
    import spart_drv_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV0       = DEF_DIV0,
    parameter logic [15:0] DIV1       = DEF_DIV1,
    parameter logic [15:0] DIV2       = DEF_DIV2,
    parameter logic [15:0] DIV3       = DEF_DIV3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    br_cfg,
    spart_echo_driver_if.master           bus,
    inout  wire  [7:0]                    databus,
    output logic [7:0]                    driver_led,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    drv_state_e  state, state_nxt;
    drv_state_e  gap_ret, gap_ret_nxt;
    logic [1:0]  cfg_q, cfg_nxt;
    logic        last_rd, last_rd_nxt;

    logic        strobe;
    logic        iorw_c;
    logic [1:0]  addr_c;
    logic [7:0]  wdata;
    logic        push;
    logic        pop;
    logic        rd_ok;
    logic        wr_ok;
    logic [15:0] div_sel;
    logic [7:0]  tx_byte;

    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;

    spart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (databus),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Divisor for the currently registered baud selection
    always_comb begin
        div_sel = DIV0;
        case (cfg_q)
            2'b00:   div_sel = DIV0;
            2'b01:   div_sel = DIV1;
            2'b10:   div_sel = DIV2;
            default: div_sel = DIV3;
        endcase
    end

    // Byte placed on the bus for an echo write
`ifdef SPART_DRV_CASE_SWAP_EN
    assign tx_byte = case_swap(fifo_dout);
`else
    assign tx_byte = fifo_dout;
`endif

    assign rd_ok = bus.rda && !fifo_full;
    assign wr_ok = bus.tbr && !fifo_empty;

    // Next-state, arbitration and strobe decode; IDLE issues its strobe in the same cycle
    always_comb begin
        state_nxt   = state;
        gap_ret_nxt = gap_ret;
        cfg_nxt     = cfg_q;
        last_rd_nxt = last_rd;
        strobe      = 1'b0;
        iorw_c      = 1'b1;
        addr_c      = ADDR_DATA;
        wdata       = 8'h00;
        push        = 1'b0;
        pop         = 1'b0;
        case (state)
            ST_CFG_LO: begin
                strobe      = 1'b1;
                iorw_c      = 1'b0;
                addr_c      = ADDR_DBL;
                wdata       = div_sel[7:0];
                state_nxt   = ST_GAP;
                gap_ret_nxt = ST_CFG_HI;
            end
            ST_CFG_HI: begin
                strobe      = 1'b1;
                iorw_c      = 1'b0;
                addr_c      = ADDR_DBH;
                wdata       = div_sel[15:8];
                state_nxt   = ST_GAP;
                gap_ret_nxt = ST_IDLE;
            end
            ST_GAP: begin
                // SPART status is stale here, so rda/tbr are not looked at
                state_nxt = gap_ret;
            end
            ST_IDLE: begin
                if (br_cfg != cfg_q) begin
                    cfg_nxt   = br_cfg;
                    state_nxt = ST_CFG_LO;
                end else if (rd_ok && (!wr_ok || !last_rd)) begin
                    strobe      = 1'b1;
                    iorw_c      = 1'b1;
                    push        = 1'b1;
                    last_rd_nxt = 1'b1;
                    state_nxt   = ST_GAP;
                    gap_ret_nxt = ST_IDLE;
                end else if (wr_ok) begin
                    strobe      = 1'b1;
                    iorw_c      = 1'b0;
                    wdata       = tx_byte;
                    pop         = 1'b1;
                    last_rd_nxt = 1'b0;
                    state_nxt   = ST_GAP;
                    gap_ret_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_CFG_LO;
        endcase
    end

    // FSM and arbitration registers; reset reloads the baud selection
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CFG_LO;
            gap_ret <= ST_CFG_HI;
            cfg_q   <= br_cfg;
            last_rd <= 1'b0;
        end else begin
            state   <= state_nxt;
            gap_ret <= gap_ret_nxt;
            cfg_q   <= cfg_nxt;
            last_rd <= last_rd_nxt;
        end
    end

    // Last byte read from the SPART, shown on the LEDs
    always_ff @(posedge clk) begin
        if (rst)
            driver_led <= 8'h00;
        else if (push)
            driver_led <= databus;
    end

    // Reset kills any strobe in the same cycle it is asserted
    assign bus.iocs   = strobe && !rst;
    assign bus.iorw   = iorw_c || rst;
    assign bus.ioaddr = rst ? ADDR_DATA : addr_c;
    assign databus    = (strobe && !iorw_c && !rst) ? wdata : 8'hzz;

endmodule

// File: tb/tb_spart_echo_driver.sv
// Bench for spart_echo_driver: a small SPART model serves bytes on reads and
// records writes; a strobe trace is checked against expectations derived from
// the intended bus behaviour.
`timescale 1ns/1ps
module tb_spart_echo_driver;
    localparam int FIFO_DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] br_cfg = 2'b01;
    wire  [7:0] databus;
    logic [7:0] driver_led;
    logic [3:0] fifo_level;

    spart_echo_driver_if bus();

    spart_echo_driver #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .bus        (bus),
        .databus    (databus),
        .driver_led (driver_led),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // SPART model
    logic [7:0] rx_mem [128];
    logic [6:0] rx_cnt = 7'd0;
    logic [6:0] rx_idx = 7'd0;
    logic       tbr_en = 1'b0;
    logic [7:0] tx_log [$];

    assign bus.rda = (rx_idx < rx_cnt);
    assign bus.tbr = tbr_en;
    assign databus = (bus.iocs && bus.iorw) ? rx_mem[rx_idx] : 8'hzz;

    always @(posedge clk) begin
        if (bus.iocs && bus.iorw && bus.ioaddr == 2'b00 && rx_idx < rx_cnt)
            rx_idx <= rx_idx + 7'd1;
        if (bus.iocs && !bus.iorw && bus.ioaddr == 2'b00)
            tx_log.push_back(databus);
    end

    // Strobe trace
    typedef struct {
        int         cyc;
        logic       rw;
        logic [1:0] addr;
        logic [7:0] data;
    } strobe_t;

    strobe_t trace [$];
    int      cyc = 0;
    logic    prev_iocs = 1'b0;
    int      n_chk = 0;
    int      n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.iocs)
            trace.push_back('{cyc, bus.iorw, bus.ioaddr, databus});
        if (prev_iocs)
            check("gap_after_strobe", {31'd0, bus.iocs}, 32'd0);
        prev_iocs <= bus.iocs;
    end

    // Reference rules
    function automatic logic [7:0] echo_of(input logic [7:0] b);
`ifdef SPART_DRV_CASE_SWAP_EN
        logic [7:0] lc;
        lc = b | 8'h20;
        if (lc >= 8'h61 && lc <= 8'h7A)
            return b ^ 8'h20;
`endif
        return b;
    endfunction

    function automatic logic [15:0] div_exp(input logic [1:0] c);
        case (c)
            2'b00:   return 16'h0516;
            2'b01:   return 16'h028B;
            2'b10:   return 16'h0146;
            default: return 16'h00A3;
        endcase
    endfunction

    function automatic strobe_t tr(input int i);
        strobe_t s;
        s = '{-1, 1'b0, 2'b00, 8'h00};
        if (i < trace.size())
            s = trace[i];
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] b);
        rx_mem[rx_cnt] = b;
        rx_cnt = rx_cnt + 7'd1;
    endtask

    task automatic wait_level(input int lvl, input int budget, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (int'(fifo_level) != lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(fifo_level), lvl);
    endtask

    task automatic check_cfg(input string tag, input logic [1:0] c);
        strobe_t    s0;
        strobe_t    s1;
        logic [15:0] d;
        d  = div_exp(c);
        s0 = tr(0);
        s1 = tr(1);
        check({tag, "_count"}, trace.size(), 2);
        check({tag, "_lo_rw"}, {31'd0, s0.rw}, 0);
        check({tag, "_lo_addr"}, {30'd0, s0.addr}, 2);
        check({tag, "_lo_data"}, {24'd0, s0.data}, {24'd0, d[7:0]});
        check({tag, "_hi_addr"}, {30'd0, s1.addr}, 3);
        check({tag, "_hi_data"}, {24'd0, s1.data}, {24'd0, d[15:8]});
        check({tag, "_spacing"}, s1.cyc - s0.cyc, 2);
    endtask

    initial begin
        strobe_t    s0;
        strobe_t    s1;
        logic [7:0] bq [$];
        int         c0;
        int         k;
        int         nrd;
        int         ntx;

        // Reset state
        rst = 1'b1;
        br_cfg = 2'b01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_iocs", {31'd0, bus.iocs}, 0);
        check("rst_iorw", {31'd0, bus.iorw}, 1);
        check("rst_ioaddr", {30'd0, bus.ioaddr}, 0);
        check("rst_led", {24'd0, driver_led}, 0);
        check("rst_level", {28'd0, fifo_level}, 0);

        // Divisor programming after reset
        step();
        rst = 1'b0;
        trace.delete();
        c0 = cyc;
        repeat (8) @(negedge clk);
        s0 = tr(0);
        check("t1_first_cycle", s0.cyc, c0);
        check_cfg("t1", 2'b01);
        check("t1_quiet", {31'd0, bus.iocs}, 0);

        // Single echo
        step();
        trace.delete();
        tbr_en = 1'b1;
        load(8'h61);
        repeat (6) @(negedge clk);
        s0 = tr(0);
        s1 = tr(1);
        check("t2_count", trace.size(), 2);
        check("t2_rd_rw", {31'd0, s0.rw}, 1);
        check("t2_rd_data", {24'd0, s0.data}, 32'h61);
        check("t2_wr_rw", {31'd0, s1.rw}, 0);
        check("t2_wr_data", {24'd0, s1.data}, {24'd0, echo_of(8'h61)});
        check("t2_latency", s1.cyc - s0.cyc, 2);
        check("t2_led", {24'd0, driver_led}, 32'h61);
        check("t2_level", {28'd0, fifo_level}, 0);

        // Fill to full with transmit blocked, then drain
        step();
        tbr_en = 1'b0;
        trace.delete();
        for (int i = 0; i < 9; i++) load(8'h30 + 8'(i));
        repeat (40) @(negedge clk);
        nrd = 0;
        foreach (trace[i]) if (trace[i].rw) nrd++;
        check("t3_reads", nrd, FIFO_DEPTH);
        check("t3_full_level", {28'd0, fifo_level}, FIFO_DEPTH);
        check("t3_held_rda", {31'd0, bus.rda}, 1);
        check("t3_led", {24'd0, driver_led}, 32'h37);
        step();
        trace.delete();
        tbr_en = 1'b1;
        repeat (60) @(negedge clk);
        k = 0;
        foreach (trace[i]) begin
            if (!trace[i].rw) begin
                check("t3_tx_data", {24'd0, trace[i].data}, {24'd0, echo_of(8'h30 + 8'(k))});
                k++;
            end
        end
        check("t3_tx_count", k, 9);
        check("t3_drained", {28'd0, fifo_level}, 0);

        // Alternation with both sides ready
        step();
        tbr_en = 1'b0;
        bq.delete();
        for (int i = 0; i < 4; i++) begin
            bq.push_back(8'($urandom_range(0, 255)));
            load(bq[i]);
        end
        wait_level(4, 40, "t4_fill");
        step();
        tbr_en = 1'b1;
        wait_level(3, 20, "t4_one_out");
        step();
        trace.delete();
        for (int i = 0; i < 6; i++) begin
            bq.push_back(8'($urandom_range(0, 255)));
            load(bq[4 + i]);
        end
        repeat (40) @(negedge clk);
        check("t4_count", trace.size(), 15);
        for (int i = 0; i < 12; i++) begin
            s0 = tr(i);
            check("t4_alternate", {31'd0, s0.rw}, {31'd0, (i % 2 == 0)});
        end
        for (int i = 1; i < 15; i++) begin
            s0 = tr(i - 1);
            s1 = tr(i);
            check("t4_spacing", s1.cyc - s0.cyc, 2);
        end
        k = 1;
        foreach (trace[i]) begin
            if (!trace[i].rw) begin
                check("t4_tx_data", {24'd0, trace[i].data}, {24'd0, echo_of(bq[k])});
                k++;
            end
        end

        // Reconfiguration with bytes waiting in the FIFO
        step();
        tbr_en = 1'b0;
        bq.delete();
        for (int i = 0; i < 2; i++) begin
            bq.push_back(8'($urandom_range(0, 255)));
            load(bq[i]);
        end
        wait_level(2, 20, "t5_fill");
        step();
        trace.delete();
        br_cfg = 2'b11;
        repeat (10) @(negedge clk);
        check_cfg("t5", 2'b11);
        check("t5_level_kept", {28'd0, fifo_level}, 2);
        step();
        trace.delete();
        tbr_en = 1'b1;
        repeat (10) @(negedge clk);
        s0 = tr(0);
        s1 = tr(1);
        check("t5_tx_count", trace.size(), 2);
        check("t5_tx0", {23'd0, s0.rw, s0.data}, {24'd0, echo_of(bq[0])});
        check("t5_tx1", {23'd0, s1.rw, s1.data}, {24'd0, echo_of(bq[1])});

        // Reset in the middle of a write strobe
        step();
        tbr_en = 1'b0;
        for (int i = 0; i < 3; i++) load(8'($urandom_range(0, 255)));
        wait_level(3, 20, "t6_fill");
        step();
        tbr_en = 1'b1;
        #2;
        check("t6_wr_active", {30'd0, bus.iocs, bus.iorw}, 32'b10);
        ntx = tx_log.size();
        rst = 1'b1;
        step();
        check("t6_iocs", {31'd0, bus.iocs}, 0);
        check("t6_not_driving", {31'd0, bus.iorw}, 1);
        check("t6_level", {28'd0, fifo_level}, 0);
        check("t6_led", {24'd0, driver_led}, 0);
        check("t6_aborted_write", tx_log.size(), ntx);
        step();
        rst = 1'b0;
        trace.delete();
        repeat (8) @(negedge clk);
        check_cfg("t6", 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Hard ceiling so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
